// File: rtl/decode_stage.sv
// decode_stage: RV32I-style decode between fetch and execute.
// Reads register-file operands, resolves EX/MEM bypass, builds immediates,
// selects ALU operands and registers them into the D/E register under a
// valid/ready handshake, with load-use bubbles and branch flush.
// Optional feature macro: DECODE_FWD_EN (EX/MEM forwarding). When it is not
// defined, operands come only from the register file and any pending EX/MEM
// writer of a used source stalls decode.
module decode_stage #(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc_in,
   input  logic [31:0]     instr_in,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] r1_val,
   input  logic [XLEN-1:0] r2_val,
   input  logic            ex_wr_en,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_val,
   input  logic            ex_is_load,
   input  logic            mem_wr_en,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] alu_1,
   output logic [XLEN-1:0] alu_2,
   output logic [XLEN-1:0] store_val,
   output logic [4:0]      rd_out,
   output logic            wr_en_out
);

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   opcode_e         opcode;
   logic [4:0]      rd_field;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            use_rs1, use_rs2, writes_rd;
   logic [XLEN-1:0] d_alu_1, d_alu_2, d_store_val;
   logic            hazard, advance, transfer;

   assign opcode   = opcode_e'(instr_in[6:0]);
   assign rd_field = instr_in[11:7];
   assign rs1_addr = instr_in[19:15];
   assign rs2_addr = instr_in[24:20];

   assign imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
   assign imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
   assign imm_b = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                   instr_in[30:25], instr_in[11:8], 1'b0};
   assign imm_u = {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'h000};
   assign imm_j = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                   instr_in[20], instr_in[30:21], 1'b0};

   // Source operand resolution; x0 always reads as zero.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
`ifdef DECODE_FWD_EN
      if (rs1_addr != 5'd0) begin
         if (ex_wr_en && ex_rd == rs1_addr && !ex_is_load) rs1_val = ex_val;
         else if (mem_wr_en && mem_rd == rs1_addr)         rs1_val = mem_val;
         else                                              rs1_val = r1_val;
      end
      if (rs2_addr != 5'd0) begin
         if (ex_wr_en && ex_rd == rs2_addr && !ex_is_load) rs2_val = ex_val;
         else if (mem_wr_en && mem_rd == rs2_addr)         rs2_val = mem_val;
         else                                              rs2_val = r2_val;
      end
`else
      if (rs1_addr != 5'd0) rs1_val = r1_val;
      if (rs2_addr != 5'd0) rs2_val = r2_val;
`endif
   end

`ifndef DECODE_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{ex_val, mem_val, ex_is_load};
`endif

   // Opcode decode: source usage, destination write and operand selection.
   always_comb begin
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      writes_rd   = 1'b0;
      d_alu_1     = '0;
      d_alu_2     = '0;
      d_store_val = '0;
      case (opcode)
         OPC_OP: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
            d_alu_1 = rs1_val; d_alu_2 = rs2_val;
         end
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            use_rs1 = 1'b1; writes_rd = 1'b1;
            d_alu_1 = rs1_val; d_alu_2 = imm_i;
         end
         OPC_STORE: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            d_alu_1 = rs1_val; d_alu_2 = imm_s; d_store_val = rs2_val;
         end
         OPC_BRANCH: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            d_alu_1 = rs1_val; d_alu_2 = rs2_val; d_store_val = imm_b;
         end
         OPC_LUI: begin
            writes_rd = 1'b1;
            d_alu_2   = imm_u;
         end
         OPC_AUIPC: begin
            writes_rd = 1'b1;
            d_alu_1 = pc_in; d_alu_2 = imm_u;
         end
         OPC_JAL: begin
            writes_rd = 1'b1;
            d_alu_1 = pc_in; d_alu_2 = imm_j;
         end
         default: ;
      endcase
   end

   // Hazard detection: load-use only with bypass, any pending writer without.
   always_comb begin
      hazard = ex_wr_en && ex_rd != 5'd0 &&
               ((use_rs1 && ex_rd == rs1_addr) || (use_rs2 && ex_rd == rs2_addr));
`ifdef DECODE_FWD_EN
      hazard = hazard && ex_is_load;
`else
      hazard = hazard || (mem_wr_en && mem_rd != 5'd0 &&
               ((use_rs1 && mem_rd == rs1_addr) || (use_rs2 && mem_rd == rs2_addr)));
`endif
   end

   assign advance  = !out_valid || out_ready;
   assign in_ready = flush || (advance && !hazard);
   assign transfer = in_valid && in_ready;

   // D/E pipeline register: reset > flush > advance (transfer or bubble).
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         pc_out    <= '0;
         instr_out <= NOP_INSTR;
         alu_1     <= '0;
         alu_2     <= '0;
         store_val <= '0;
         rd_out    <= '0;
         wr_en_out <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         instr_out <= NOP_INSTR;
         wr_en_out <= 1'b0;
      end else if (advance) begin
         if (transfer) begin
            out_valid <= 1'b1;
            pc_out    <= pc_in;
            instr_out <= instr_in;
            alu_1     <= d_alu_1;
            alu_2     <= d_alu_2;
            store_val <= d_store_val;
            rd_out    <= (writes_rd && rd_field != 5'd0) ? rd_field : 5'd0;
            wr_en_out <= writes_rd && rd_field != 5'd0;
         end else begin
            out_valid <= 1'b0;
            instr_out <= NOP_INSTR;
            wr_en_out <= 1'b0;
         end
      end
   end

endmodule
